stopwatch_lap: RTL and testbench

- Parametrised lap stopwatch, successor to the single-interval timer.
- Counts ticks from a single-cycle tick strobe, which is a synchronous enable in the clk domain and not a clock.
- Stores up to LAP_DEPTH lap times in a circular buffer and shows a captured lap for a programmable hold time while counting continues.
- Stored laps can be recalled newest-to-oldest while paused. Sits between the key debouncers / 1 ms tick generator and the 7-segment display formatter.

---
 rtl/stopwatch_lap_if.sv | 31 +++
 rtl/stopwatch_lap.sv | 207 ++++++++++++++++++++
 tb/tb_stopwatch_lap.sv | 213 +++++++++++++++++++++
 3 files changed

// File: rtl/stopwatch_lap_if.sv
// Key/tick strobes into the lap stopwatch and the registered values it presents to the display side.
interface stopwatch_lap_if #(
    parameter int CNT_W     = 20,
    parameter int LAP_DEPTH = 8
);
    localparam int PW   = $clog2(LAP_DEPTH);
    localparam int LN_W = PW + 1;

    logic             tick_1ms;
    logic             start_key;
    logic             lap_key;
    logic             recall_key;
    logic             clr_key;
    logic [CNT_W-1:0] t;
    logic [CNT_W-1:0] t_disp;
    logic [LN_W-1:0]  lap_num;
    logic [PW-1:0]    lap_idx;
    logic             running;
    logic             wrapped;
    logic             lap_ovf;

    modport master (
        output tick_1ms, start_key, lap_key, recall_key, clr_key,
        input  t, t_disp, lap_num, lap_idx, running, wrapped, lap_ovf
    );

    modport slave (
        input  tick_1ms, start_key, lap_key, recall_key, clr_key,
        output t, t_disp, lap_num, lap_idx, running, wrapped, lap_ovf
    );
endinterface

// File: rtl/stopwatch_lap.sv
// Lap stopwatch: tick counter with a circular lap buffer, timed lap hold on the display
// and newest-to-oldest recall while paused.
//
// state    | meaning
// ---------+------------------------------------------------------------
// S_IDLE   | cleared, t = 0, waiting for start
// S_RUN    | counting ticks, laps captured, optional display hold
// S_PAUSED | counter frozen, display shows t
// S_RECALL | counter frozen, display shows buffer entry rd_ptr
module stopwatch_lap #(
    parameter int CNT_W      = 20,
    parameter int MAX_COUNT  = 999999,
    parameter int LAP_DEPTH  = 8,
    parameter int HOLD_TICKS = 3200
) (
    input  logic          clk,
    input  logic          KEY2,
    stopwatch_lap_if.slave sw
);
    localparam int PW     = $clog2(LAP_DEPTH);
    localparam int LN_W   = PW + 1;
    localparam int HOLD_W = $clog2(HOLD_TICKS + 1);

    typedef enum logic [1:0] {S_IDLE, S_RUN, S_PAUSED, S_RECALL} state_t;

    state_t            state_q, state_d;
    logic [CNT_W-1:0]  t_q, t_d;
    logic [CNT_W-1:0]  t_disp_q, t_disp_d;
    logic [LN_W-1:0]   lap_num_q, lap_num_d;
    logic [PW-1:0]     lap_idx_q, lap_idx_d;
    logic              running_q, running_d;
    logic              wrapped_q, wrapped_d;
    logic              lap_ovf_q, lap_ovf_d;
    logic [PW-1:0]     wr_ptr_q, wr_ptr_d;
    logic [PW-1:0]     rd_ptr_q, rd_ptr_d;
    logic [LN_W-1:0]   shown_q, shown_d;
    logic [HOLD_W-1:0] hold_cnt_q, hold_cnt_d;
    logic [CNT_W-1:0]  lap_buf_q [LAP_DEPTH];
    logic              lap_we;

    logic k_clr, k_start, k_lap, k_recall;
    logic [CNT_W-1:0] t_inc;
    logic             at_max;

    // One key per cycle wins; the rest are dropped even if the winner is ignored in this state.
    assign k_clr    = sw.clr_key;
    assign k_start  = sw.start_key & ~sw.clr_key;
    assign k_lap    = sw.lap_key & ~sw.start_key & ~sw.clr_key;
    assign k_recall = sw.recall_key & ~sw.lap_key & ~sw.start_key & ~sw.clr_key;

    assign at_max = (t_q == CNT_W'(MAX_COUNT));
    assign t_inc  = at_max ? '0 : t_q + CNT_W'(1);

    always_comb begin
        state_d    = state_q;
        t_d        = t_q;
        t_disp_d   = t_disp_q;
        lap_num_d  = lap_num_q;
        lap_idx_d  = lap_idx_q;
        running_d  = running_q;
        wrapped_d  = wrapped_q;
        lap_ovf_d  = lap_ovf_q;
        wr_ptr_d   = wr_ptr_q;
        rd_ptr_d   = rd_ptr_q;
        shown_d    = shown_q;
        hold_cnt_d = hold_cnt_q;
        lap_we     = 1'b0;

        case (state_q)
            S_IDLE: begin
                t_d      = '0;
                t_disp_d = '0;
                if (k_start) begin
                    state_d   = S_RUN;
                    running_d = 1'b1;
                end
            end

            S_RUN: begin
                if (sw.tick_1ms) begin
                    t_d = t_inc;
                    if (at_max) wrapped_d = 1'b1;
                end
                // Display is released one cycle after the hold reaches zero.
                if (hold_cnt_q != '0) begin
                    if (sw.tick_1ms) hold_cnt_d = hold_cnt_q - HOLD_W'(1);
                end else begin
                    t_disp_d = t_d;
                end
                if (k_start) begin
                    state_d    = S_PAUSED;
                    running_d  = 1'b0;
                    hold_cnt_d = '0;
                    t_disp_d   = t_d;
                end else if (k_lap) begin
                    lap_we   = 1'b1;
                    wr_ptr_d = wr_ptr_q + PW'(1);
                    if (lap_num_q == LN_W'(LAP_DEPTH)) lap_ovf_d = 1'b1;
                    else lap_num_d = lap_num_q + LN_W'(1);
                    t_disp_d   = t_q;
                    hold_cnt_d = HOLD_W'(HOLD_TICKS);
                end
            end

            S_PAUSED: begin
                t_disp_d   = t_q;
                hold_cnt_d = '0;
                if (k_clr) begin
                    state_d   = S_IDLE;
                    t_d       = '0;
                    t_disp_d  = '0;
                    lap_num_d = '0;
                    lap_idx_d = '0;
                    wr_ptr_d  = '0;
                    rd_ptr_d  = '0;
                    shown_d   = '0;
                    wrapped_d = 1'b0;
                    lap_ovf_d = 1'b0;
                end else if (k_start) begin
                    state_d   = S_RUN;
                    running_d = 1'b1;
                end else if (k_recall && lap_num_q != '0) begin
                    state_d   = S_RECALL;
                    rd_ptr_d  = wr_ptr_q - PW'(1);
                    shown_d   = LN_W'(1);
                    lap_idx_d = rd_ptr_d;
                    t_disp_d  = lap_buf_q[rd_ptr_d];
                end
            end

            S_RECALL: begin
                if (k_clr) begin
                    state_d   = S_IDLE;
                    t_d       = '0;
                    t_disp_d  = '0;
                    lap_num_d = '0;
                    lap_idx_d = '0;
                    wr_ptr_d  = '0;
                    rd_ptr_d  = '0;
                    shown_d   = '0;
                    wrapped_d = 1'b0;
                    lap_ovf_d = 1'b0;
                end else if (k_start) begin
                    state_d   = S_RUN;
                    running_d = 1'b1;
                    t_disp_d  = t_q;
                    lap_idx_d = '0;
                end else if (k_recall) begin
                    if (shown_q < lap_num_q) begin
                        rd_ptr_d  = rd_ptr_q - PW'(1);
                        shown_d   = shown_q + LN_W'(1);
                        lap_idx_d = rd_ptr_d;
                        t_disp_d  = lap_buf_q[rd_ptr_d];
                    end else begin
                        state_d   = S_PAUSED;
                        t_disp_d  = t_q;
                        lap_idx_d = '0;
                    end
                end
            end

            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge KEY2) begin
        if (!KEY2) begin
            state_q    <= S_IDLE;
            t_q        <= '0;
            t_disp_q   <= '0;
            lap_num_q  <= '0;
            lap_idx_q  <= '0;
            running_q  <= 1'b0;
            wrapped_q  <= 1'b0;
            lap_ovf_q  <= 1'b0;
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            shown_q    <= '0;
            hold_cnt_q <= '0;
        end else begin
            state_q    <= state_d;
            t_q        <= t_d;
            t_disp_q   <= t_disp_d;
            lap_num_q  <= lap_num_d;
            lap_idx_q  <= lap_idx_d;
            running_q  <= running_d;
            wrapped_q  <= wrapped_d;
            lap_ovf_q  <= lap_ovf_d;
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            shown_q    <= shown_d;
            hold_cnt_q <= hold_cnt_d;
        end
    end

    always_ff @(posedge clk) begin
        if (lap_we) lap_buf_q[wr_ptr_q] <= t_q;
    end

    assign sw.t       = t_q;
    assign sw.t_disp  = t_disp_q;
    assign sw.lap_num = lap_num_q;
    assign sw.lap_idx = lap_idx_q;
    assign sw.running = running_q;
    assign sw.wrapped = wrapped_q;
    assign sw.lap_ovf = lap_ovf_q;
endmodule

// File: tb/tb_stopwatch_lap.sv
// Directed bench for stopwatch_lap with CNT_W=8, MAX_COUNT=9, LAP_DEPTH=4, HOLD_TICKS=3.
module tb_stopwatch_lap;
    logic clk;
    logic KEY2;
    int   n_chk;
    int   n_bad;

    stopwatch_lap_if #(.CNT_W(8), .LAP_DEPTH(4)) sw_if ();

    stopwatch_lap #(
        .CNT_W(8), .MAX_COUNT(9), .LAP_DEPTH(4), .HOLD_TICKS(3)
    ) dut (
        .clk (clk),
        .KEY2(KEY2),
        .sw  (sw_if)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    // Drive one cycle of strobes, then return 1 time unit after the edge that samples them.
    task automatic step(input logic tk, input logic st, input logic lp,
                        input logic rc, input logic cl);
        sw_if.tick_1ms   = tk;
        sw_if.start_key  = st;
        sw_if.lap_key    = lp;
        sw_if.recall_key = rc;
        sw_if.clr_key    = cl;
        @(posedge clk);
        #1;
        sw_if.tick_1ms   = 1'b0;
        sw_if.start_key  = 1'b0;
        sw_if.lap_key    = 1'b0;
        sw_if.recall_key = 1'b0;
        sw_if.clr_key    = 1'b0;
    endtask

    task automatic tick1();
        step(1, 0, 0, 0, 0);
        step(0, 0, 0, 0, 0);
    endtask

    task automatic do_reset();
        KEY2 = 1'b0;
        #2;
        KEY2 = 1'b1;
        @(posedge clk);
        #1;
    endtask

    initial begin
        n_chk = 0;
        n_bad = 0;
        KEY2  = 1'b0;
        sw_if.tick_1ms   = 1'b0;
        sw_if.start_key  = 1'b0;
        sw_if.lap_key    = 1'b0;
        sw_if.recall_key = 1'b0;
        sw_if.clr_key    = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_t", sw_if.t, 0);
        chk("rst_t_disp", sw_if.t_disp, 0);
        chk("rst_lap_num", sw_if.lap_num, 0);
        chk("rst_lap_idx", sw_if.lap_idx, 0);
        chk("rst_running", sw_if.running, 0);
        chk("rst_wrapped", sw_if.wrapped, 0);
        chk("rst_lap_ovf", sw_if.lap_ovf, 0);
        KEY2 = 1'b1;
        @(posedge clk);
        #1;

        // ticks in IDLE are ignored
        tick1();
        chk("idle_tick_t", sw_if.t, 0);

        // 1: count through the wrap, then pause
        step(0, 1, 0, 0, 0);
        chk("t1_running", sw_if.running, 1);
        for (int i = 1; i <= 12; i++) begin
            tick1();
            chk("t1_t", sw_if.t, i % 10);
            chk("t1_t_disp", sw_if.t_disp, i % 10);
            chk("t1_wrapped", sw_if.wrapped, (i >= 10) ? 1 : 0);
        end
        step(0, 1, 0, 0, 0);
        chk("t1_paused_running", sw_if.running, 0);
        repeat (3) tick1();
        chk("t1_paused_t", sw_if.t, 2);

        // 2: lap together with the 6th tick, hold for 3 ticks
        do_reset();
        step(0, 1, 0, 0, 0);
        repeat (5) tick1();
        chk("t2_t5", sw_if.t, 5);
        step(1, 0, 1, 0, 0);
        chk("t2_t_after_lap", sw_if.t, 6);
        chk("t2_disp_after_lap", sw_if.t_disp, 5);
        chk("t2_lap_num", sw_if.lap_num, 1);
        tick1();
        chk("t2_hold1_t", sw_if.t, 7);
        chk("t2_hold1_disp", sw_if.t_disp, 5);
        tick1();
        chk("t2_hold2_t", sw_if.t, 8);
        chk("t2_hold2_disp", sw_if.t_disp, 5);
        tick1();
        chk("t2_release_t", sw_if.t, 9);
        chk("t2_release_disp", sw_if.t_disp, 9);
        step(0, 1, 0, 0, 0);
        step(0, 0, 0, 1, 0);
        chk("t2_recall_disp", sw_if.t_disp, 5);
        chk("t2_recall_idx", sw_if.lap_idx, 0);

        // 3: five laps into a four-entry buffer, then recall all
        do_reset();
        step(0, 1, 0, 0, 0);
        for (int i = 1; i <= 5; i++) begin
            tick1();
            step(0, 0, 1, 0, 0);
            chk("t3_ovf", sw_if.lap_ovf, (i == 5) ? 1 : 0);
        end
        chk("t3_lap_num", sw_if.lap_num, 4);
        step(0, 1, 0, 0, 0);
        chk("t3_paused_disp", sw_if.t_disp, 5);
        begin
            logic [7:0] exp_disp [4];
            logic [1:0] exp_idx [4];
            exp_disp = '{8'd5, 8'd4, 8'd3, 8'd2};
            exp_idx  = '{2'd0, 2'd3, 2'd2, 2'd1};
            for (int i = 0; i < 4; i++) begin
                step(0, 0, 0, 1, 0);
                chk("t3_recall_disp", sw_if.t_disp, exp_disp[i]);
                chk("t3_recall_idx", sw_if.lap_idx, exp_idx[i]);
            end
        end
        tick1();
        chk("t3_recall_frozen_t", sw_if.t, 5);
        step(0, 0, 0, 1, 0);
        chk("t3_back_idx", sw_if.lap_idx, 0);
        chk("t3_back_disp", sw_if.t_disp, 5);
        chk("t3_back_running", sw_if.running, 0);
        step(0, 1, 0, 0, 0);
        chk("t3_resume_running", sw_if.running, 1);
        tick1();
        chk("t3_resume_t", sw_if.t, 6);
        step(0, 1, 0, 0, 0);

        // 4: clr beats start in PAUSED; start beats lap in RUN
        step(0, 1, 0, 0, 1);
        chk("t4_clr_t", sw_if.t, 0);
        chk("t4_clr_lap_num", sw_if.lap_num, 0);
        chk("t4_clr_ovf", sw_if.lap_ovf, 0);
        chk("t4_clr_running", sw_if.running, 0);
        step(0, 1, 0, 0, 0);
        tick1();
        tick1();
        step(0, 1, 1, 0, 0);
        chk("t4_startlap_running", sw_if.running, 0);
        chk("t4_startlap_lap_num", sw_if.lap_num, 0);
        chk("t4_startlap_disp", sw_if.t_disp, 2);

        // 5: empty recall ignored; clr/recall ignored while running
        step(0, 0, 0, 1, 0);
        chk("t5_empty_recall_idx", sw_if.lap_idx, 0);
        chk("t5_empty_recall_disp", sw_if.t_disp, 2);
        step(0, 1, 0, 0, 0);
        chk("t5_running", sw_if.running, 1);
        step(0, 0, 0, 0, 1);
        step(0, 0, 0, 1, 0);
        chk("t5_clr_ignored_t", sw_if.t, 2);
        tick1();
        chk("t5_count_t", sw_if.t, 3);
        chk("t5_count_running", sw_if.running, 1);

        // 6: async reset in the middle of a hold
        repeat (4) tick1();
        step(0, 0, 1, 0, 0);
        chk("t6_lap_disp", sw_if.t_disp, 7);
        #2;
        KEY2 = 1'b0;
        #1;
        chk("t6_async_t", sw_if.t, 0);
        chk("t6_async_disp", sw_if.t_disp, 0);
        chk("t6_async_lap_num", sw_if.lap_num, 0);
        chk("t6_async_running", sw_if.running, 0);
        @(posedge clk);
        #1;
        KEY2 = 1'b1;
        @(posedge clk);
        #1;
        step(0, 1, 0, 0, 0);
        tick1();
        chk("t6_restart_t", sw_if.t, 1);
        chk("t6_restart_disp", sw_if.t_disp, 1);

        $display("test done: total=%0d bad=%0d", n_chk, n_bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: got no finish expected finish");
        $fatal(1, "timeout");
    end
endmodule
